// File: rtl/hrm_io_bridge_if.sv
// Signal bundle between the bridge, the serial front end, the CPU INBOX/OUTBOX
// ports and the tx sink. The slave view belongs to the bridge; the master view
// belongs to whatever surrounds it.
interface hrm_io_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clr_err;
  logic       cpu_in_full;
  logic       cpu_in_wr;
  logic [7:0] cpu_in_data;
  logic       cpu_out_empty;
  logic [7:0] cpu_out_data;
  logic       cpu_out_rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       rx_overrun;
  logic [7:0] in_count;
  logic [7:0] out_count;

  modport slave (
    input  rx_data, rx_valid, clr_err, cpu_in_full, cpu_out_empty, cpu_out_data, tx_ready,
    output cpu_in_wr, cpu_in_data, cpu_out_rd, tx_data, tx_valid, rx_overrun, in_count,
           out_count
  );

  modport master (
    output rx_data, rx_valid, clr_err, cpu_in_full, cpu_out_empty, cpu_out_data, tx_ready,
    input  cpu_in_wr, cpu_in_data, cpu_out_rd, tx_data, tx_valid, rx_overrun, in_count,
           out_count
  );
endinterface

// File: rtl/hrm_io_bridge.sv
// Byte-stream bridge: rx bytes go through a local FIFO into the CPU INBOX,
// OUTBOX bytes are drained to a valid/ready tx sink. Both paths are independent.
module hrm_io_bridge #(
  parameter int unsigned IN_LGFLEN = 3
) (
  input  logic            clk,
  input  logic            i_rst_n,
  hrm_io_bridge_if.slave  bus
);

  localparam int unsigned Depth = 2 ** IN_LGFLEN;
  localparam logic [IN_LGFLEN:0] PtrOne = 1;

  typedef enum logic [1:0] {InIdle, InWr, InGap} in_state_e;
  typedef enum logic [1:0] {OutIdle, OutPop, OutSend, OutWait} out_state_e;

  logic [7:0]         fifo_mem [Depth];
  logic [IN_LGFLEN:0] wr_ptr_q, rd_ptr_q;
  logic               fifo_empty, fifo_full, fifo_rd, fifo_wr, rx_drop;
  logic               overrun_q;

  in_state_e          in_state_q;
  logic               in_wr_q;
  logic [7:0]         in_data_q;
  logic [7:0]         in_count_q;

  out_state_e         out_state_q;
  logic               out_rd_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;
  logic [7:0]         out_count_q;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IN_LGFLEN] != rd_ptr_q[IN_LGFLEN]) &&
                      (wr_ptr_q[IN_LGFLEN-1:0] == rd_ptr_q[IN_LGFLEN-1:0]);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign fifo_rd = (in_state_q == InIdle) && !fifo_empty && !bus.cpu_in_full;
  assign fifo_wr = bus.rx_valid && (!fifo_full || fifo_rd);
  assign rx_drop = bus.rx_valid && fifo_full && !fifo_rd;

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q[IN_LGFLEN-1:0]] <= bus.rx_data;
  end

  // FIFO pointers and sticky overrun (a new drop beats a simultaneous clear).
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (rx_drop)          overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
    end
  end

  // Inbound FSM: strobe, data and count are registered on entry to InWr.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_state_q <= InIdle;
      in_wr_q    <= 1'b0;
      in_data_q  <= 8'h00;
      in_count_q <= 8'h00;
    end else begin
      case (in_state_q)
        InIdle: begin
          if (fifo_rd) begin
            in_state_q <= InWr;
            in_wr_q    <= 1'b1;
            in_data_q  <= fifo_mem[rd_ptr_q[IN_LGFLEN-1:0]];
            in_count_q <= in_count_q + 8'd1;
          end
        end
        InWr: begin
          in_wr_q    <= 1'b0;
          in_state_q <= InGap;
        end
        InGap:   in_state_q <= InIdle;
        default: begin
          in_state_q <= InIdle;
          in_wr_q    <= 1'b0;
        end
      endcase
    end
  end

  // Outbound FSM: one byte outstanding; pop, hold for the sink, then let empty settle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_state_q <= OutIdle;
      out_rd_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      out_count_q <= 8'h00;
    end else begin
      case (out_state_q)
        OutIdle: begin
          if (!bus.cpu_out_empty) begin
            out_state_q <= OutPop;
            out_rd_q    <= 1'b1;
          end
        end
        OutPop: begin
          out_rd_q    <= 1'b0;
          tx_data_q   <= bus.cpu_out_data;
          tx_valid_q  <= 1'b1;
          out_state_q <= OutSend;
        end
        OutSend: begin
          if (bus.tx_ready) begin
            tx_valid_q  <= 1'b0;
            out_count_q <= out_count_q + 8'd1;
            out_state_q <= OutWait;
          end
        end
        OutWait: out_state_q <= OutIdle;
        default: begin
          out_state_q <= OutIdle;
          out_rd_q    <= 1'b0;
          tx_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_in_wr   = in_wr_q;
  assign bus.cpu_in_data = in_data_q;
  assign bus.in_count    = in_count_q;
  assign bus.cpu_out_rd  = out_rd_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.out_count   = out_count_q;
  assign bus.rx_overrun  = overrun_q;

endmodule

// File: tb/tb_hrm_io_bridge.sv
// Directed bench for hrm_io_bridge: vector table plus multi-cycle sequences.
module tb_hrm_io_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hrm_io_bridge_if bus ();

  hrm_io_bridge #(.IN_LGFLEN(3)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // OUTBOX model: registered-style head pointer advanced on the pop strobe.
  logic [7:0] ob_mem [1024];
  int ob_head = 0;
  int ob_tail = 0;
  assign bus.cpu_out_empty = (ob_head == ob_tail);
  assign bus.cpu_out_data  = ob_mem[ob_head % 1024];

  logic [7:0] in_log[$];
  int         in_cyc[$];
  logic [7:0] tx_log[$];
  int cyc = 0;
  int rd_cnt = 0;
  int pop_while_valid = 0;
  int wr_while_full = 0;

  // Monitor: sample DUT outputs at the edge where they take effect.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cpu_in_wr) begin
      in_log.push_back(bus.cpu_in_data);
      in_cyc.push_back(cyc);
      if (bus.cpu_in_full) wr_while_full++;
    end
    if (bus.cpu_out_rd) begin
      rd_cnt++;
      if (bus.tx_valid) pop_while_valid++;
      ob_head <= ob_head + 1;
    end
    if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ob_push(input logic [7:0] b);
    ob_mem[ob_tail % 1024] = b;
    ob_tail = ob_tail + 1;
  endtask

  task automatic wait_in(input int n, input int bound, input string name);
    int k = 0;
    while (in_log.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, in_log.size(), n);
  endtask

  task automatic wait_tx(input int n, input int bound, input string name);
    int k = 0;
    while (tx_log.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, tx_log.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] rx;
    logic [7:0] exp_in;
    logic [7:0] exp_in_cnt;
    logic [7:0] ob;
    logic [7:0] exp_tx;
    logic [7:0] exp_out_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_in, base_tx, c0, bad;

    vecs[0] = '{8'h00, 8'h00, 8'd2, 8'hFF, 8'hFF, 8'd1};
    vecs[1] = '{8'hA5, 8'hA5, 8'd3, 8'h5A, 8'h5A, 8'd2};
    vecs[2] = '{8'hFF, 8'hFF, 8'd4, 8'h00, 8'h00, 8'd3};
    vecs[3] = '{8'h3C, 8'h3C, 8'd5, 8'hC3, 8'hC3, 8'd4};
    vecs[4] = '{8'h80, 8'h80, 8'd6, 8'h01, 8'h01, 8'd5};

    // Reset held with rx traffic and a ready sink.
    rst_n           = 1'b0;
    bus.rx_data     = 8'h99;
    bus.rx_valid    = 1'b1;
    bus.clr_err     = 1'b0;
    bus.cpu_in_full = 1'b0;
    bus.tx_ready    = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_in_wr", bus.cpu_in_wr, 0);
    chk("rst_in_data", bus.cpu_in_data, 0);
    chk("rst_out_rd", bus.cpu_out_rd, 0);
    chk("rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    chk("rst_flags_counts", {bus.rx_overrun, bus.in_count, bus.out_count}, 0);
    bus.rx_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_push", in_log.size(), 0);

    // First byte after reset: push two cycles after the FIFO write.
    bus.rx_data  = 8'h41;
    bus.rx_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    wait_in(1, 20, "first_push_seen");
    chk("first_data", in_log[0], 8'h41);
    chk("first_latency", in_cyc[0], c0 + 2);
    chk("first_in_count", bus.in_count, 8'd1);

    // Vector table: inbound and outbound bytes in parallel.
    for (int i = 0; i < 5; i++) begin
      base_in = in_log.size();
      base_tx = tx_log.size();
      bus.rx_data  = vecs[i].rx;
      bus.rx_valid = 1'b1;
      ob_push(vecs[i].ob);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      wait_in(base_in + 1, 20, $sformatf("vec%0d_push_seen", i));
      wait_tx(base_tx + 1, 20, $sformatf("vec%0d_tx_seen", i));
      chk($sformatf("vec%0d_in_data", i), in_log[base_in], vecs[i].exp_in);
      chk($sformatf("vec%0d_tx_data", i), tx_log[base_tx], vecs[i].exp_tx);
      chk($sformatf("vec%0d_in_count", i), bus.in_count, vecs[i].exp_in_cnt);
      chk($sformatf("vec%0d_out_count", i), bus.out_count, vecs[i].exp_out_cnt);
    end
    repeat (4) @(negedge clk);

    // Burst of 8 back-to-back bytes: in order, 3-cycle spacing, no overrun.
    base_in = in_log.size();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data  = 8'h10 + 8'(i);
      bus.rx_valid = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    wait_in(base_in + 8, 60, "burst_all_seen");
    bad = 0;
    for (int i = 0; i < 8; i++) if (in_log[base_in + i] !== 8'h10 + 8'(i)) bad++;
    chk("burst_order", bad, 0);
    chk("burst_first_latency", in_cyc[base_in], c0 + 2);
    bad = 0;
    for (int i = 1; i < 8; i++) if (in_cyc[base_in + i] - in_cyc[base_in + i - 1] != 3) bad++;
    chk("burst_spacing", bad, 0);
    chk("burst_no_overrun", bus.rx_overrun, 0);
    chk("burst_in_count", bus.in_count, 8'h0E);
    repeat (4) @(negedge clk);

    // INBOX full: 8 bytes buffered, 9th dropped; clear and clear-vs-overrun.
    base_in = in_log.size();
    bus.cpu_in_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.rx_data  = 8'h20 + 8'(i);
      bus.rx_valid = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chk("full_overrun_set", bus.rx_overrun, 1);
    repeat (3) @(negedge clk);
    chk("full_no_push", in_log.size(), base_in);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr_err_clears", bus.rx_overrun, 0);
    bus.rx_data  = 8'h30;
    bus.rx_valid = 1'b1;
    bus.clr_err  = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.clr_err  = 1'b0;
    chk("overrun_beats_clear", bus.rx_overrun, 1);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    chk("clr_err_again", bus.rx_overrun, 0);
    bus.cpu_in_full = 1'b0;
    wait_in(base_in + 8, 60, "full_release_seen");
    repeat (6) @(negedge clk);
    chk("full_release_exact", in_log.size(), base_in + 8);
    bad = 0;
    for (int i = 0; i < 8; i++) if (in_log[base_in + i] !== 8'h20 + 8'(i)) bad++;
    chk("full_release_order", bad, 0);
    chk("full_in_count", bus.in_count, 8'h16);

    // OUTBOX 0x05,0xFB with a stalled sink: one pop, data held.
    do_reset();
    base_tx = tx_log.size();
    c0 = rd_cnt;
    bus.tx_ready = 1'b0;
    ob_push(8'h05);
    ob_push(8'hFB);
    repeat (10) @(negedge clk);
    chk("stall_one_pop", rd_cnt - c0, 1);
    chk("stall_valid", bus.tx_valid, 1);
    chk("stall_data", bus.tx_data, 8'h05);
    bus.tx_ready = 1'b1;
    wait_tx(base_tx + 2, 30, "stall_release_seen");
    chk("stall_first", tx_log[base_tx], 8'h05);
    chk("stall_second", tx_log[base_tx + 1], 8'hFB);
    @(negedge clk);
    chk("stall_out_count", bus.out_count, 8'd2);

    // 256 outbound transfers from reset wrap the counter back to zero.
    do_reset();
    base_tx = tx_log.size();
    for (int i = 0; i < 256; i++) ob_push(8'(i));
    wait_tx(base_tx + 256, 1200, "wrap_all_seen");
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tx_log[base_tx + i] !== 8'(i)) bad++;
    chk("wrap_data", bad, 0);
    chk("wrap_out_count", bus.out_count, 8'h00);
    repeat (4) @(negedge clk);

    // Reset mid OUT_SEND and IN_GAP: outputs drop at once, no stale strobes.
    bus.tx_ready = 1'b0;
    ob_push(8'h77);
    c0 = 0;
    while (!bus.tx_valid && c0 < 20) begin
      @(negedge clk);
      c0++;
    end
    chk("mid_tx_valid_up", bus.tx_valid, 1);
    bus.rx_data  = 8'h99;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    c0 = 0;
    while (!bus.cpu_in_wr && c0 < 20) begin
      @(negedge clk);
      c0++;
    end
    chk("mid_in_wr_up", bus.cpu_in_wr, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_in_wr", bus.cpu_in_wr, 0);
    chk("mid_rst_counts", {bus.in_count, bus.out_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base_in = in_log.size();
    base_tx = tx_log.size();
    c0 = rd_cnt;
    bus.tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", {in_log.size() - base_in, tx_log.size() - base_tx, rd_cnt - c0}, 0);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    ob_push(8'h66);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    wait_in(base_in + 1, 20, "post_rst_push_seen");
    wait_tx(base_tx + 1, 20, "post_rst_tx_seen");
    chk("post_rst_in_data", in_log[base_in], 8'h5A);
    chk("post_rst_tx_data", tx_log[base_tx], 8'h66);
    @(negedge clk);
    chk("post_rst_counts", {bus.in_count, bus.out_count}, 16'h0101);

    chk("never_pop_while_valid", pop_while_valid, 0);
    chk("never_push_while_full", wr_while_full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
